// File: rtl/mux_lane_collector.sv
// Rebuilds an 8-bit word from a (lane select, bit) serial stream.
// A completed word is held on a valid/ready output until the consumer takes it.
module mux_lane_collector (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  input  logic       din,
  input  logic [2:0] s,
  output logic       in_ready,
  output logic [7:0] word,
  output logic       word_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] fill_cnt
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0] r_state;
  logic [7:0] r_mask;
  logic [7:0] r_word;
  logic       r_dup;

  logic       w_acc;
  logic [7:0] w_mask_next;
  logic [3:0] w_cnt;

  // in_ready comes from the state register alone, so there is no path from in_valid or out_ready.
  assign in_ready    = (r_state == ST_FILL);
  assign out_valid   = (r_state == ST_FULL);
  assign w_acc       = in_valid & in_ready;
  assign w_mask_next = r_mask | (8'b1 << s);

  assign word     = out_valid ? r_word : 8'h00;
  assign word_err = out_valid & r_dup;
  assign fill_cnt = w_cnt;

  always_comb begin
    // NOTE: default before the loop so every path assigns w_cnt and no latch is inferred.
    w_cnt = 4'd0;
    for (int k = 0; k < 8; k++) begin
      w_cnt = w_cnt + {3'b000, r_mask[k]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FILL;
      r_mask  <= 8'h00;
      r_word  <= 8'h00;
      r_dup   <= 1'b0;
    end else if (clr) begin
      r_state <= ST_FILL;
      r_mask  <= 8'h00;
      r_word  <= 8'h00;
      r_dup   <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_acc) begin
            r_word[s] <= din;
            r_mask    <= w_mask_next;
            if (r_mask[s]) begin
              r_dup <= 1'b1;
            end
            if (w_mask_next == 8'hFF) begin
              r_state <= ST_FULL;
            end
          end
        end
        ST_FULL: begin
          // r_word is kept; it is only meaningful again once out_valid rises.
          if (out_ready) begin
            r_state <= ST_FILL;
            r_mask  <= 8'h00;
            r_dup   <= 1'b0;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_lane_collector.sv
// Directed bench for mux_lane_collector: fills, backpressure, duplicates,
// clear, asynchronous reset and back-to-back words.
module tb_mux_lane_collector;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       din;
  logic [2:0] s;
  logic       in_ready;
  logic [7:0] word;
  logic       word_err;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] fill_cnt;

  int n_tests;
  int n_fail;
  int n_cyc;

  mux_lane_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .din       (din),
    .s         (s),
    .in_ready  (in_ready),
    .word      (word),
    .word_err  (word_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill_cnt  (fill_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle 1 ns past it before anything is sampled.
  task automatic tick();
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  task automatic send(input logic [2:0] lane, input logic bit_val);
    in_valid = 1'b1;
    s        = lane;
    din      = bit_val;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word_fwd(input logic [7:0] v);
    for (int k = 0; k < 8; k++) begin
      send(3'(k), v[k]);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    n_tests   = 0;
    n_fail    = 0;
    n_cyc     = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    din       = 1'b0;
    s         = 3'd0;
    out_ready = 1'b0;

    #2;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_word",      word,      8'h00);
    check("rst_word_err",  word_err,  0);
    check("rst_fill_cnt",  fill_cnt,  0);
    #10 rst_n = 1'b1;
    @(negedge clk);

    // Sequential fill of 0xA5.
    v = 8'hA5;
    send(3'd0, v[0]);
    check("seq_fill1", fill_cnt, 1);
    for (int k = 1; k < 8; k++) send(3'(k), v[k]);
    check("seq_valid",    out_valid, 1);
    check("seq_word",     word,      8'hA5);
    check("seq_err",      word_err,  0);
    check("seq_in_ready", in_ready,  0);
    check("seq_fill8",    fill_cnt,  8);
    handshake();
    check("seq_done_valid", out_valid, 0);
    check("seq_done_ready", in_ready,  1);
    check("seq_done_fill",  fill_cnt,  0);

    // Reverse order with a 5-cycle stall and ignored in_valid pulses.
    v = 8'h3C;
    for (int k = 7; k >= 0; k--) send(3'(k), v[k]);
    check("rev_valid", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      s        = 3'(c);
      din      = ~c[1];
      tick();
      check("rev_stall_word",  word,      8'h3C);
      check("rev_stall_ready", in_ready,  0);
      check("rev_stall_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    handshake();
    check("rev_done_valid", out_valid, 0);
    tick();
    check("rev_single_valid", out_valid, 0);
    check("rev_single_fill",  fill_cnt,  0);

    // Duplicate lane 2: last write wins and the word is flagged.
    send(3'd2, 1'b1);
    check("dup_fill_a", fill_cnt, 1);
    send(3'd2, 1'b0);
    check("dup_fill_b", fill_cnt, 1);
    send(3'd0, 1'b1);
    send(3'd1, 1'b1);
    for (int k = 3; k < 8; k++) send(3'(k), 1'b1);
    check("dup_valid", out_valid, 1);
    check("dup_word",  word,      8'hFB);
    check("dup_err",   word_err,  1);
    handshake();
    send_word_fwd(8'h5A);
    check("dup_next_word", word,     8'h5A);
    check("dup_next_err",  word_err, 0);
    handshake();

    // Clear mid-word overrides a simultaneous accept.
    for (int k = 0; k < 4; k++) send(3'(k), 1'b1);
    check("clr_fill4", fill_cnt, 4);
    clr      = 1'b1;
    in_valid = 1'b1;
    s        = 3'd4;
    din      = 1'b1;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    check("clr_fill0", fill_cnt, 0);
    send_word_fwd(8'hC3);
    check("clr_next_valid", out_valid, 1);
    check("clr_next_word",  word,      8'hC3);
    check("clr_next_err",   word_err,  0);
    handshake();

    // Asynchronous reset while a flagged word is pending.
    send(3'd0, 1'b1);
    send_word_fwd(8'h96);
    check("ar_pre_valid", out_valid, 1);
    check("ar_pre_err",   word_err,  1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid",    out_valid, 0);
    check("ar_ready",    in_ready,  1);
    check("ar_word",     word,      8'h00);
    check("ar_err",      word_err,  0);
    check("ar_fill",     fill_cnt,  0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("ar_rel_ready", in_ready, 1);
    check("ar_rel_fill",  fill_cnt, 0);

    // Back-to-back 0x01 then 0xFE with out_ready held high.
    out_ready = 1'b1;
    n_cyc     = 0;
    v         = 8'h01;
    for (int k = 0; k < 8; k++) send(3'(k), v[k]);
    check("b2b_w1_valid", out_valid, 1);
    check("b2b_w1_word",  word,      8'h01);
    v        = 8'hFE;
    in_valid = 1'b1;
    s        = 3'd0;
    din      = v[0];
    tick();
    check("b2b_hs_valid", out_valid, 0);
    check("b2b_hs_fill",  fill_cnt,  0);
    check("b2b_hs_ready", in_ready,  1);
    tick();
    check("b2b_first_fill", fill_cnt, 1);
    for (int k = 1; k < 8; k++) send(3'(k), v[k]);
    check("b2b_w2_valid", out_valid, 1);
    check("b2b_w2_word",  word,      8'hFE);
    check("b2b_w2_err",   word_err,  0);
    tick();
    check("b2b_w2_done",  out_valid, 0);
    check("b2b_cycles",   n_cyc,     18);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
